q3_sweep_checker: RTL

Sequential stimulus-and-compare stage that sits directly upstream of the 4-input q3 logic function. It drives the gate-level and UDP implementations with a shared input vector {x,y,z,m}. On each `start` it sweeps all 16 input combinations in ascending order and holds each one for a programmable settle time. It compares the two implementations' outputs and reports a mismatch count, the first failing vector and a pass flag. This replaces hand-written per-vector stimulus with one exhaustive, self-checking sweep.

---
 rtl/q3_sweep_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/q3_sweep_checker.sv
`timescale 1ns/1ps
// Exhaustive stimulus/compare stage for the 4-input q3 function: sweeps {x,y,z,m}
// over 0..15, compares the gate-level output against the UDP golden output.
module q3_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_a,
    input  logic       dut_b,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       m,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail,
    output logic       fail_valid
);

    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 5;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [VEC_W-1:0] WLOAD = VEC_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST  = VEC_W'(15);

    logic [1:0]       state, state_nx;
    logic [VEC_W-1:0] vec, vec_nx;
    logic [VEC_W-1:0] wcnt, wcnt_nx;
    logic [VEC_W-1:0] ff_nx;
    logic [CNT_W-1:0] err_nx;
    logic             fv_nx;
    logic             pass_nx;
    logic             mis;

    // Next-state and next-value logic; sampling happens when the settle counter hits zero
    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        wcnt_nx  = wcnt;
        err_nx   = err_cnt;
        ff_nx    = first_fail;
        fv_nx    = fail_valid;
        pass_nx  = pass;
        mis      = dut_a ^ dut_b;
        case (state)
            IDLE: begin
                if (start) begin
                    vec_nx   = '0;
                    wcnt_nx  = WLOAD;
                    err_nx   = '0;
                    fv_nx    = 1'b0;
                    ff_nx    = '0;
                    pass_nx  = 1'b0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (wcnt != '0) begin
                    wcnt_nx = wcnt - VEC_W'(1);
                end else begin
                    if (mis) begin
                        err_nx = err_cnt + CNT_W'(1);
                        if (!fail_valid) begin
                            ff_nx = vec;
                            fv_nx = 1'b1;
                        end
                    end
                    if (vec != LAST) begin
                        vec_nx  = vec + VEC_W'(1);
                        wcnt_nx = WLOAD;
                    end else begin
                        // pass is settled together with the final error update
                        pass_nx  = (err_nx == '0);
                        state_nx = FIN;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            wcnt       <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            vec        <= vec_nx;
            wcnt       <= wcnt_nx;
            err_cnt    <= err_nx;
            first_fail <= ff_nx;
            fail_valid <= fv_nx;
            pass       <= pass_nx;
            busy       <= (state_nx == RUN);
            done       <= (state_nx == FIN);
        end
    end

    assign {x, y, z, m} = vec;

endmodule
